// File: rtl/cdma_pkg.sv
// Shared defaults and helpers for the CDMA datapath buffer.
package cdma_pkg;

  localparam int unsigned CDMA_BUF_DW    = 32;
  localparam int unsigned CDMA_BUF_DEPTH = 24;

  // Ceiling log2, usable in parameter defaults; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    longint unsigned x;
    r = 0;
    x = 1;
    while (x < longint'(v)) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cdma_fifo_if.sv
// Handshake/status bundle between a CDMA buffer and its producer/consumer.
interface cdma_fifo_if #(
  parameter int unsigned DW = cdma_pkg::CDMA_BUF_DW,
  parameter int unsigned CW = cdma_pkg::clog2(cdma_pkg::CDMA_BUF_DEPTH + 1)
);
  logic          flush;
  logic          err_clr;
  logic          wr;
  logic [DW-1:0] wdata;
  logic          full;
  logic          afull;
  logic [CW-1:0] empty_word;
  logic          rd;
  logic [DW-1:0] rdata;
  logic          empty;
  logic          aempty;
  logic [CW-1:0] buf_word;
  logic [CW-1:0] peak_word;
  logic          ovf;
  logic          udf;

  modport master (
    output flush, err_clr, wr, wdata, rd,
    input  full, afull, empty_word, rdata, empty, aempty, buf_word, peak_word, ovf, udf
  );

  modport slave (
    input  flush, err_clr, wr, wdata, rd,
    output full, afull, empty_word, rdata, empty, aempty, buf_word, peak_word, ovf, udf
  );
endinterface

// File: rtl/cdma_fifo_ptr.sv
// Phase/index wrap counter; index runs 0..DEPTH-1 and the phase bit flips on wrap.
module cdma_fifo_ptr #(
  parameter int unsigned DEPTH = 24,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic          phase,
  output logic [AW-1:0] idx
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= 1'b0;
      idx   <= '0;
    end else if (clr) begin
      phase <= 1'b0;
      idx   <= '0;
    end else if (inc) begin
      if (idx == AW'(DEPTH - 1)) begin
        idx   <= '0;
        phase <= ~phase;
      end else begin
        idx <= idx + AW'(1);
      end
    end
  end

endmodule

// File: rtl/cdma_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy, watermark and sticky error reporting.
module cdma_fifo
  import cdma_pkg::*;
#(
  parameter int unsigned DW    = CDMA_BUF_DW,
  parameter int unsigned DEPTH = CDMA_BUF_DEPTH,
  parameter int unsigned CW    = clog2(DEPTH + 1),
  parameter int unsigned AW    = clog2(DEPTH),
  parameter int unsigned AF_TH = DEPTH - 4,
  parameter int unsigned AE_TH = 4
) (
  input  logic         clk,
  input  logic         rst,
  cdma_fifo_if.slave   bus
);

  logic          wphase, rphase;
  logic [AW-1:0] widx, ridx;
  logic          full, empty;
  logic          wr_acc, rd_acc;
  logic [CW-1:0] buf_word, buf_nxt, empty_word, peak_word;
  logic          ovf, udf;
  logic [DW-1:0] mem [DEPTH];

  assign empty  = (wphase == rphase) && (widx == ridx);
  assign full   = (wphase != rphase) && (widx == ridx);
  // flush wins over both strobes so neither advances a pointer that same cycle
  assign wr_acc = bus.wr & ~full  & ~bus.flush;
  assign rd_acc = bus.rd & ~empty & ~bus.flush;

  cdma_fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wptr (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.flush),
    .inc   (wr_acc),
    .phase (wphase),
    .idx   (widx)
  );

  cdma_fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rptr (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.flush),
    .inc   (rd_acc),
    .phase (rphase),
    .idx   (ridx)
  );

  always_ff @(posedge clk) begin
    if (wr_acc) mem[widx] <= bus.wdata;
  end

  always_comb begin
    buf_nxt = buf_word;
    if (bus.flush)          buf_nxt = '0;
    else if (wr_acc && !rd_acc) buf_nxt = buf_word + CW'(1);
    else if (rd_acc && !wr_acc) buf_nxt = buf_word - CW'(1);
  end

  // Occupancy, free count and high-water mark all track the same next value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_word   <= '0;
      empty_word <= CW'(DEPTH);
      peak_word  <= '0;
    end else begin
      buf_word   <= buf_nxt;
      empty_word <= CW'(DEPTH) - buf_nxt;
      if (bus.err_clr || (buf_nxt > peak_word)) peak_word <= buf_nxt;
    end
  end

  // A new error event outranks err_clr in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= (bus.wr & full  & ~bus.flush) | (ovf & ~bus.err_clr);
      udf <= (bus.rd & empty & ~bus.flush) | (udf & ~bus.err_clr);
    end
  end

  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.afull      = buf_word >= CW'(AF_TH);
  assign bus.aempty     = buf_word <= CW'(AE_TH);
  assign bus.rdata      = mem[ridx];
  assign bus.buf_word   = buf_word;
  assign bus.empty_word = empty_word;
  assign bus.peak_word  = peak_word;
  assign bus.ovf        = ovf;
  assign bus.udf        = udf;

endmodule

// File: tb/tb_cdma_fifo.sv
// Directed self-checking bench for cdma_fifo: 32x24 default build and an 8x5 build.
module tb_cdma_fifo;

  logic clk;
  logic rst_a, rst_b;
  int   n_chk  = 0;
  int   n_fail = 0;

  cdma_fifo_if #(.DW(32), .CW(5)) bus_a ();
  cdma_fifo_if #(.DW(8),  .CW(3)) bus_b ();

  cdma_fifo #(.DW(32), .DEPTH(24)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  cdma_fifo #(.DW(8),  .DEPTH(5))  dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rep;
    int wr;
    int rd;
    int fl;
    int clr;
    int buf_n;
    int ovf;
    int udf;
    int peak;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.wr = 1'b0; bus_a.rd = 1'b0; bus_a.flush = 1'b0; bus_a.err_clr = 1'b0;
  endtask

  task automatic idle_b();
    bus_b.wr = 1'b0; bus_b.rd = 1'b0; bus_b.flush = 1'b0; bus_b.err_clr = 1'b0;
  endtask

  task automatic check_a_level(input string tag, input int b);
    check({tag, " buf_word"},   32'(bus_a.buf_word),   32'(b));
    check({tag, " empty_word"}, 32'(bus_a.empty_word), 32'(24 - b));
    check({tag, " full"},       32'(bus_a.full),       32'(b == 24));
    check({tag, " empty"},      32'(bus_a.empty),      32'(b == 0));
    check({tag, " afull"},      32'(bus_a.afull),      32'(b >= 20));
    check({tag, " aempty"},     32'(bus_a.aempty),     32'(b <= 4));
  endtask

  initial begin
    int wd;
    idle_a();
    idle_b();
    bus_a.wdata = '0;
    bus_b.wdata = '0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #12;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #2;

    // ---- 32x24: reset state ----
    check_a_level("rst", 0);
    check("rst peak", 32'(bus_a.peak_word), 32'd0);
    check("rst ovf",  32'(bus_a.ovf), 32'd0);
    check("rst udf",  32'(bus_a.udf), 32'd0);

    // ---- fill 24 words ----
    for (int i = 0; i < 24; i++) begin
      bus_a.wr = 1'b1;
      bus_a.wdata = 32'h100 + 32'(i);
      tick();
      check_a_level($sformatf("fill%0d", i), i + 1);
      if (i == 0) check("fwft head", bus_a.rdata, 32'h100);
    end
    bus_a.wdata = 32'hDEAD;
    tick();
    bus_a.wr = 1'b0;
    check("ovf at full", 32'(bus_a.ovf), 32'd1);
    check_a_level("ovf", 24);
    check("peak full", 32'(bus_a.peak_word), 32'd24);

    // ---- drain 24 words, no bubble ----
    bus_a.rd = 1'b1;
    for (int i = 0; i < 24; i++) begin
      check($sformatf("drain rdata%0d", i), bus_a.rdata, 32'h100 + 32'(i));
      tick();
    end
    check_a_level("drained", 0);
    check("udf before", 32'(bus_a.udf), 32'd0);
    tick();
    bus_a.rd = 1'b0;
    check("udf extra rd", 32'(bus_a.udf), 32'd1);
    check_a_level("extra rd", 0);

    bus_a.err_clr = 1'b1;
    tick();
    bus_a.err_clr = 1'b0;
    check("clr ovf",  32'(bus_a.ovf), 32'd0);
    check("clr udf",  32'(bus_a.udf), 32'd0);
    check("clr peak", 32'(bus_a.peak_word), 32'd0);

    // ---- wrap: occupancy 3, 30 write/read pairs ----
    bus_a.wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_a.wdata = 32'h200 + 32'(i);
      tick();
    end
    bus_a.rd = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bus_a.wdata = 32'h203 + 32'(i);
      check($sformatf("wrap rdata%0d", i), bus_a.rdata, 32'h200 + 32'(i));
      tick();
      check($sformatf("wrap buf%0d", i), 32'(bus_a.buf_word), 32'd3);
    end
    idle_a();
    check("wrap peak", 32'(bus_a.peak_word), 32'd3);
    check("wrap head", bus_a.rdata, 32'h21E);

    // ---- table: flush, simultaneous wr/rd at the boundaries, err_clr ----
    //            rep wr rd fl clr buf ovf udf peak
    tbl[0]  = '{ 1, 1, 1, 1, 0,  0, 0, 0,  3};
    tbl[1]  = '{ 1, 1, 1, 0, 0,  1, 0, 1,  3};
    tbl[2]  = '{ 1, 0, 0, 0, 1,  1, 0, 0,  1};
    tbl[3]  = '{23, 1, 0, 0, 0, 24, 0, 0, 24};
    tbl[4]  = '{ 1, 1, 1, 0, 0, 23, 1, 0, 24};
    tbl[5]  = '{13, 0, 1, 0, 0, 10, 1, 0, 24};
    tbl[6]  = '{10, 0, 1, 0, 0,  0, 1, 0, 24};
    tbl[7]  = '{ 1, 0, 1, 0, 0,  0, 1, 1, 24};
    tbl[8]  = '{10, 1, 0, 0, 0, 10, 1, 1, 24};
    tbl[9]  = '{ 1, 1, 1, 1, 0,  0, 1, 1, 24};
    tbl[10] = '{ 1, 0, 0, 0, 1,  0, 0, 0,  0};
    tbl[11] = '{ 1, 1, 0, 0, 1,  1, 0, 0,  1};
    wd = 32'h300;
    for (int k = 0; k < 12; k++) begin
      for (int r = 0; r < tbl[k].rep; r++) begin
        bus_a.wr      = tbl[k].wr[0];
        bus_a.rd      = tbl[k].rd[0];
        bus_a.flush   = tbl[k].fl[0];
        bus_a.err_clr = tbl[k].clr[0];
        bus_a.wdata   = 32'(wd);
        wd++;
        tick();
      end
      idle_a();
      check_a_level($sformatf("vec%0d", k), tbl[k].buf_n);
      check($sformatf("vec%0d ovf", k),  32'(bus_a.ovf),       32'(tbl[k].ovf));
      check($sformatf("vec%0d udf", k),  32'(bus_a.udf),       32'(tbl[k].udf));
      check($sformatf("vec%0d peak", k), 32'(bus_a.peak_word), 32'(tbl[k].peak));
    end
    check("post-flush head", bus_a.rdata, 32'(wd - 1));

    // ---- 8x5 build: reset, fill, overflow, drain ----
    check("b rst buf",   32'(bus_b.buf_word),   32'd0);
    check("b rst ew",    32'(bus_b.empty_word), 32'd5);
    check("b rst empty", 32'(bus_b.empty),      32'd1);
    check("b rst afull", 32'(bus_b.afull),      32'd0);
    bus_b.wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_b.wdata = 8'hA0 + 8'(i);
      tick();
      check($sformatf("b fill buf%0d", i),   32'(bus_b.buf_word),   32'(i + 1));
      check($sformatf("b fill ew%0d", i),    32'(bus_b.empty_word), 32'(4 - i));
      check($sformatf("b fill full%0d", i),  32'(bus_b.full),       32'(i == 4));
      check($sformatf("b fill afull%0d", i), 32'(bus_b.afull),      32'd1);
    end
    bus_b.wdata = 8'hFF;
    tick();
    check("b ovf", 32'(bus_b.ovf), 32'd1);
    bus_b.wr = 1'b0;
    bus_b.rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("b drain rdata%0d", i), 32'(bus_b.rdata), 32'hA0 + 32'(i));
      tick();
    end
    bus_b.rd = 1'b0;
    check("b drained empty", 32'(bus_b.empty), 32'd1);
    check("b drained buf",   32'(bus_b.buf_word), 32'd0);

    // ---- 8x5: async reset in the middle of a fill ----
    bus_b.wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_b.wdata = 8'h50 + 8'(i);
      tick();
    end
    check("b midfill buf", 32'(bus_b.buf_word), 32'd3);
    #2;
    rst_b = 1'b1;
    #1;
    check("b arst buf",   32'(bus_b.buf_word),   32'd0);
    check("b arst ew",    32'(bus_b.empty_word), 32'd5);
    check("b arst empty", 32'(bus_b.empty),      32'd1);
    check("b arst full",  32'(bus_b.full),       32'd0);
    check("b arst afull", 32'(bus_b.afull),      32'd0);
    check("b arst aempty",32'(bus_b.aempty),     32'd1);
    check("b arst peak",  32'(bus_b.peak_word),  32'd0);
    check("b arst ovf",   32'(bus_b.ovf),        32'd0);
    check("b arst udf",   32'(bus_b.udf),        32'd0);
    tick();
    check("b held buf", 32'(bus_b.buf_word), 32'd0);
    rst_b = 1'b0;
    bus_b.wdata = 8'h5A;
    tick();
    idle_b();
    check("b post-rst buf",   32'(bus_b.buf_word), 32'd1);
    check("b post-rst rdata", 32'(bus_b.rdata),    32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
